// File: rtl/uart_rx_frame.sv
//------------------------------------------------------------------------------
// uart_rx_frame
//
// UART frame receiver for a TX-only peer. Deserialises
//   start bit, 8 data bits (LSB first), optional parity bit, one stop bit
// using 16x oversampling with mid-bit sampling, and reports each byte
// together with per-frame error flags.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz; sets the oversample divisor
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   parity_type  00 none, 01 odd, 10 even, 11 none (latched at start detect)
//   baud_rate    00 2400, 01 4800, 10 9600, 11 19200 (latched at start detect)
//   data_tx      serial line, idle high, asynchronous to clock
//   data_out     last received byte, updated only when done_flag pulses
//   error_flag   [0] parity, [1] start, [2] stop error; valid with done_flag
//   active_flag  high while a frame is being received
//   done_flag    one-cycle pulse at end of frame
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_frame #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic       data_tx,
    output logic [7:0] data_out,
    output logic [2:0] error_flag,
    output logic       active_flag,
    output logic       done_flag
);

    // Oversample divisors, one per selectable baud rate.
    localparam int unsigned DIV_2400  = CLK_FREQ / (16 * 2400);
    localparam int unsigned DIV_4800  = CLK_FREQ / (16 * 4800);
    localparam int unsigned DIV_9600  = CLK_FREQ / (16 * 9600);
    localparam int unsigned DIV_19200 = CLK_FREQ / (16 * 19200);

    // The slowest rate has the largest divisor and sets the counter width.
    localparam int unsigned CNT_W = (DIV_2400 > 1) ? $clog2(DIV_2400) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic             w_rx_s;
    logic             w_fall;

    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] w_div_max;
    logic             w_tick;

    logic [3:0]       r_samp;
    logic [3:0]       w_samp_next;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic [1:0]       r_parity;
    logic [1:0]       w_parity_next;
    logic [1:0]       r_baud;
    logic [1:0]       w_baud_next;

    logic             r_err_par;
    logic             w_err_par_next;
    logic             r_err_start;
    logic             w_err_start_next;
    logic             r_err_stop;
    logic             w_err_stop_next;

    logic [7:0]       r_data_out;
    logic [2:0]       r_err_out;

    logic             w_par_en;
    logic             w_par_xor;
    logic             w_bit_mid;
    logic             w_enter_done;

    //--------------------------------------------------------------------------
    // Input synchroniser and falling-edge detect on the synchronised line.
    // r_rx_prev is a third stage used only for edge detection, so a line that
    // is already low when the FSM returns to IDLE does not look like a start.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= data_tx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;
    assign w_fall = r_rx_prev & ~w_rx_s;

    //--------------------------------------------------------------------------
    // Oversample tick generator, running at 16x the latched baud rate.
    //--------------------------------------------------------------------------
    always_comb begin
        case (r_baud)
            2'b00:   w_div_max = CNT_W'(DIV_2400 - 1);
            2'b01:   w_div_max = CNT_W'(DIV_4800 - 1);
            2'b10:   w_div_max = CNT_W'(DIV_9600 - 1);
            default: w_div_max = CNT_W'(DIV_19200 - 1);
        endcase
    end

    // Gated in IDLE so a divisor of 1 cannot tick while waiting for a start.
    assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == w_div_max);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if ((r_state == S_IDLE) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Frame FSM: next-state and datapath next values.
    //--------------------------------------------------------------------------
    assign w_par_en  = (r_parity == 2'b01) || (r_parity == 2'b10);
    assign w_par_xor = (^r_shift) ^ w_rx_s;
    assign w_bit_mid = (r_samp == 4'd15);

    always_comb begin
        w_state_next     = r_state;
        w_samp_next      = r_samp;
        w_bit_next       = r_bit;
        w_shift_next     = r_shift;
        w_parity_next    = r_parity;
        w_baud_next      = r_baud;
        w_err_par_next   = r_err_par;
        w_err_start_next = r_err_start;
        w_err_stop_next  = r_err_stop;

        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_parity_next    = parity_type;
                    w_baud_next      = baud_rate;
                    w_samp_next      = '0;
                    w_bit_next       = '0;
                    w_err_par_next   = 1'b0;
                    w_err_start_next = 1'b0;
                    w_err_stop_next  = 1'b0;
                    w_state_next     = S_START;
                end
            end

            // Mid start bit is the 8th tick; after that every bit centre is
            // 16 ticks apart, so the sample counter restarts from zero here.
            S_START: begin
                if (w_tick) begin
                    if (r_samp == 4'd7) begin
                        w_samp_next = '0;
                        if (!w_rx_s) begin
                            w_state_next = S_DATA;
                        end else begin
                            w_err_start_next = 1'b1;
                            w_state_next     = S_DONE;
                        end
                    end else begin
                        w_samp_next = r_samp + 4'd1;
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    if (w_bit_mid) begin
                        w_samp_next  = '0;
                        w_shift_next = {w_rx_s, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_next = w_par_en ? S_PARITY : S_STOP;
                        end
                    end else begin
                        w_samp_next = r_samp + 4'd1;
                    end
                end
            end

            // Odd parity wants an odd number of ones over data+parity.
            S_PARITY: begin
                if (w_tick) begin
                    if (w_bit_mid) begin
                        w_samp_next    = '0;
                        w_err_par_next = (r_parity == 2'b01) ? ~w_par_xor : w_par_xor;
                        w_state_next   = S_STOP;
                    end else begin
                        w_samp_next = r_samp + 4'd1;
                    end
                end
            end

            // Finishing at mid stop bit leaves half a bit of margin for a
            // back-to-back start edge to be seen in IDLE.
            S_STOP: begin
                if (w_tick) begin
                    if (w_bit_mid) begin
                        w_samp_next     = '0;
                        w_err_stop_next = ~w_rx_s;
                        w_state_next    = S_DONE;
                    end else begin
                        w_samp_next = r_samp + 4'd1;
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and datapath registers.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_samp      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_parity    <= '0;
            r_baud      <= '0;
            r_err_par   <= 1'b0;
            r_err_start <= 1'b0;
            r_err_stop  <= 1'b0;
        end else begin
            r_samp      <= w_samp_next;
            r_bit       <= w_bit_next;
            r_shift     <= w_shift_next;
            r_parity    <= w_parity_next;
            r_baud      <= w_baud_next;
            r_err_par   <= w_err_par_next;
            r_err_start <= w_err_start_next;
            r_err_stop  <= w_err_stop_next;
        end
    end

    //--------------------------------------------------------------------------
    // Result registers, loaded on the edge that enters DONE so that they
    // change in the same cycle done_flag rises. Loading from the next-value
    // nets captures the final sample taken on that same edge.
    //--------------------------------------------------------------------------
    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_out <= '0;
            r_err_out  <= '0;
        end else if (w_enter_done) begin
            if (!w_err_start_next) begin
                r_data_out <= w_shift_next;
            end
            r_err_out <= {w_err_stop_next, w_err_start_next, w_err_par_next};
        end
    end

    assign data_out    = r_data_out;
    assign error_flag  = r_err_out;
    assign done_flag   = (r_state == S_DONE);
    assign active_flag = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);

endmodule
